// File: rtl/cmd_sequencer_if.sv
// Request/command bundle between the requesters and the command sequencer.
// The master side drives requests; the slave side (the sequencer) answers
// with the command word and the completion pulses.
interface cmd_sequencer_if;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        clr_req;
  logic [15:0] cmd_out;
  logic [3:0]  ack;
  logic        clr_ack;
  logic [1:0]  grant_id;
  logic        busy;

  modport master (
    output req, req_addr, req_data, clr_req,
    input  cmd_out, ack, clr_ack, grant_id, busy
  );

  modport slave (
    input  req, req_addr, req_data, clr_req,
    output cmd_out, ack, clr_ack, grant_id, busy
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Command sequencer: round-robin arbitration of four requesters onto the
// control logic unit command word, with an interleaved CLR command path.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing in flight; arbitrate CLR first, then requesters
// SETUP  | address/payload presented, strobe low (1 cycle)
// STROBE | strobe high (STB_LEN cycles)
// HOLD   | strobe low, address/payload kept stable (HOLD_LEN cycles)
// CLEAR  | CLR bit presented alone (1 cycle)
// DONE   | completion pulse to the requester or CLR source (1 cycle)
module cmd_sequencer #(
  parameter int unsigned STB_LEN  = 1,
  parameter int unsigned HOLD_LEN = 4
) (
  input logic            CLK,
  input logic            RST_n,
  cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CLEAR  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  last_grant, last_grant_nxt;
  logic [1:0]  winner, idx;
  logic        found;
  logic        clr_pend, clr_pend_nxt;
  logic        clr_path, clr_path_nxt;
  logic [4:0]  addr_q, addr_nxt;
  logic [7:0]  data_q, data_nxt;
  logic [15:0] cmd_q, cmd_nxt;
  logic [3:0]  ack_q, ack_nxt;
  logic        clr_ack_q, clr_ack_nxt;
  logic [1:0]  gid_q, gid_nxt;
  logic        busy_q, busy_nxt;

  assign bus.cmd_out  = cmd_q;
  assign bus.ack      = ack_q;
  assign bus.clr_ack  = clr_ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;

  // Round-robin pick: first active request after the last granted index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next state, phase timer and the registered output values of that state.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    clr_path_nxt   = clr_path;
    addr_nxt       = addr_q;
    data_nxt       = data_q;
    clr_pend_nxt   = clr_pend | bus.clr_req;

    case (state)
      IDLE: begin
        if (clr_pend) begin
          // A clr_req arriving now merges with the one being served.
          state_nxt    = CLEAR;
          clr_pend_nxt = 1'b0;
          clr_path_nxt = 1'b1;
          addr_nxt     = '0;
          data_nxt     = '0;
        end else if (|bus.req) begin
          state_nxt      = SETUP;
          last_grant_nxt = winner;
          clr_path_nxt   = 1'b0;
          addr_nxt       = bus.req_addr[5*winner +: 5];
          data_nxt       = bus.req_data[8*winner +: 8];
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = 4'(STB_LEN - 1);
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = 4'(HOLD_LEN - 1);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CLEAR: begin
        state_nxt = HOLD;
        cnt_nxt   = 4'(HOLD_LEN - 1);
      end
      HOLD: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    cmd_nxt     = '0;
    ack_nxt     = '0;
    clr_ack_nxt = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    gid_nxt     = (state_nxt == IDLE || clr_path_nxt) ? 2'd0 : last_grant_nxt;
    case (state_nxt)
      SETUP:  cmd_nxt = {3'b000, addr_nxt, data_nxt};
      STROBE: cmd_nxt = {3'b010, addr_nxt, data_nxt};
      HOLD:   cmd_nxt = {3'b000, addr_nxt, data_nxt};
      CLEAR:  cmd_nxt = 16'h8000;
      DONE: begin
        if (clr_path_nxt) clr_ack_nxt = 1'b1;
        else              ack_nxt     = 4'b0001 << last_grant_nxt;
      end
      default: cmd_nxt = '0;
    endcase
  end

  // State, context and output registers; reset abandons any command in flight.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 2'd3;
      clr_pend   <= 1'b0;
      clr_path   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cmd_q      <= '0;
      ack_q      <= '0;
      clr_ack_q  <= 1'b0;
      gid_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      clr_pend   <= clr_pend_nxt;
      clr_path   <= clr_path_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      cmd_q      <= cmd_nxt;
      ack_q      <= ack_nxt;
      clr_ack_q  <= clr_ack_nxt;
      gid_q      <= gid_nxt;
      busy_q     <= busy_nxt;
    end
  end

endmodule
